qos_wrr_arbiter: RTL and testbench

//  Weighted round-robin scheduler for the 4-class QoS PCIe datapath.

---
 rtl/qos_pkg.sv | 13 +
 rtl/rr_next_sel.sv | 29 ++
 rtl/qos_wrr_arbiter.sv | 122 ++++++++++++
 tb/tb_qos_wrr_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/qos_pkg.sv
// Shared constants and state encoding for the QoS weighted round-robin arbiter.
package qos_pkg;

  localparam int NUM_CLASSES = 4;
  localparam int CLASS_IDX_W = 2;
  localparam int WEIGHT_W    = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

endpackage

// File: rtl/rr_next_sel.sv
// Rotate-priority picker: first eligible class after ptr, wrapping, ptr itself last.
module rr_next_sel
  import qos_pkg::*;
(
  input  logic [NUM_CLASSES-1:0] eligible,
  input  logic [CLASS_IDX_W-1:0] ptr,
  output logic [CLASS_IDX_W-1:0] sel,
  output logic                   any
);

  logic [CLASS_IDX_W-1:0] idx;
  logic                   found;

  // Scan ptr+1 .. ptr+4; the 2-bit wrap makes ptr+4 land on ptr itself.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    any   = |eligible;
    for (int k = 1; k <= NUM_CLASSES; k++) begin
      idx = ptr + CLASS_IDX_W'(k);
      if (!found && eligible[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qos_wrr_arbiter.sv
// Weighted round-robin pop scheduler for four QoS class FIFOs.
// pop is Mealy on the current class, empty flags and downstream back-pressure;
// valid_out marks the cycle the popped FIFO data is present downstream.
module qos_wrr_arbiter #(
  parameter int NUM_CLASSES = 4,
  parameter int WEIGHT_W    = 4
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic [NUM_CLASSES-1:0] fifo_empty,
  input  logic                   down_almost_full,
  input  logic [WEIGHT_W-1:0]    weight_0,
  input  logic [WEIGHT_W-1:0]    weight_1,
  input  logic [WEIGHT_W-1:0]    weight_2,
  input  logic [WEIGHT_W-1:0]    weight_3,
  output logic [NUM_CLASSES-1:0] pop,
  output logic [1:0]             grant_id,
  output logic                   valid_out
);

  import qos_pkg::*;

  state_e                 state_q, state_d;
  logic [1:0]             cur_q, cur_d;
  logic [WEIGHT_W-1:0]    credit_q, credit_d;
  logic                   valid_out_q;

  logic [WEIGHT_W-1:0]    weight_arr [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] eligible;
  logic [1:0]             nxt_sel;
  logic                   any_elig;
  logic [NUM_CLASSES-1:0] pop_w;

  assign weight_arr[0] = weight_0;
  assign weight_arr[1] = weight_1;
  assign weight_arr[2] = weight_2;
  assign weight_arr[3] = weight_3;

  // A class competes only when it has data and a non-zero weight.
  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_elig
      assign eligible[gi] = !fifo_empty[gi] && (weight_arr[gi] != '0);
    end
  endgenerate

  rr_next_sel u_next_sel (
    .eligible (eligible),
    .ptr      (cur_q),
    .sel      (nxt_sel),
    .any      (any_elig)
  );

  // Pop the current class while serving it, unless downstream is nearly full.
  always_comb begin
    pop_w = '0;
    if (state_q == ST_SERVE && eligible[cur_q] && !down_almost_full) begin
      pop_w[cur_q] = 1'b1;
    end
  end

  // Next-state logic: turn bookkeeping, credit countdown and reload.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    credit_d = credit_q;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          cur_d    = nxt_sel;
          credit_d = weight_arr[nxt_sel];
          state_d  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (down_almost_full) begin
          // Stall wins over everything, including a drained FIFO: hold.
        end else if (eligible[cur_q]) begin
          if (credit_q > WEIGHT_W'(1)) begin
            credit_d = credit_q - WEIGHT_W'(1);
          end else begin
            cur_d    = nxt_sel;
            credit_d = weight_arr[nxt_sel];
          end
        end else if (any_elig) begin
          // Current class drained or disabled: forfeit credit, move on (one bubble).
          cur_d    = nxt_sel;
          credit_d = weight_arr[nxt_sel];
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, class pointer and credit registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      credit_q <= credit_d;
    end
  end

  // FIFO read data lags pop by one cycle, so valid_out is pop registered.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= |pop_w;
    end
  end

  assign pop       = pop_w;
  assign grant_id  = cur_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_qos_wrr_arbiter.sv
// Directed bench for qos_wrr_arbiter: fixed stimulus steps, hand-computed expectations.
module tb_qos_wrr_arbiter;

  logic       clk;
  logic       reset_L;
  logic [3:0] fifo_empty;
  logic       down_almost_full;
  logic [3:0] weight_0, weight_1, weight_2, weight_3;
  logic [3:0] pop;
  logic [1:0] grant_id;
  logic       valid_out;

  int vectors;
  int miscompares;

  logic [3:0] exp1 [8];
  logic [1:0] gnt1 [8];
  logic [3:0] exp2 [9];

  qos_wrr_arbiter #(.NUM_CLASSES(4), .WEIGHT_W(4)) dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .fifo_empty       (fifo_empty),
    .down_almost_full (down_almost_full),
    .weight_0         (weight_0),
    .weight_1         (weight_1),
    .weight_2         (weight_2),
    .weight_3         (weight_3),
    .pop              (pop),
    .grant_id         (grant_id),
    .valid_out        (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic do_reset();
    reset_L          = 1'b0;
    fifo_empty       = 4'hF;
    down_almost_full = 1'b0;
    step();
    step();
    reset_L = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp1 = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    gnt1 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp2 = '{4'h2, 4'h1, 4'h1, 4'h1, 4'h2, 4'h1, 4'h1, 4'h1, 4'h2};
    weight_0 = 4'd0; weight_1 = 4'd0; weight_2 = 4'd0; weight_3 = 4'd0;
    reset_L          = 1'b0;
    fifo_empty       = 4'hF;
    down_almost_full = 1'b0;
    #3;
    chk("rst_pop", {4'h0, pop}, 8'h00);
    chk("rst_valid", {7'h0, valid_out}, 8'h00);
    chk("rst_grant", {6'h0, grant_id}, 8'h00);

    // 1: all weights 1, all FIFOs non-empty -> one pop per class in rotation.
    do_reset();
    weight_0 = 4'd1; weight_1 = 4'd1; weight_2 = 4'd1; weight_3 = 4'd1;
    fifo_empty = 4'h0;
    #1;
    chk("t1_idle_pop", {4'h0, pop}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t1_pop%0d", i), {4'h0, pop}, {4'h0, exp1[i]});
      chk($sformatf("t1_gnt%0d", i), {6'h0, grant_id}, {6'h0, gnt1[i]});
      chk($sformatf("t1_vld%0d", i), {7'h0, valid_out}, (i == 0) ? 8'h00 : 8'h01);
    end

    // 2: weights 3,1,0,0 -> classes 2 and 3 disabled, class 0 gets three pops per turn.
    do_reset();
    weight_0 = 4'd3; weight_1 = 4'd1; weight_2 = 4'd0; weight_3 = 4'd0;
    fifo_empty = 4'h0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("t2_pop%0d", i), {4'h0, pop}, {4'h0, exp2[i]});
    end

    // 3: weight_0=4, three stall cycles after class 0's second pop.
    do_reset();
    weight_0 = 4'd4; weight_1 = 4'd1; weight_2 = 4'd0; weight_3 = 4'd0;
    fifo_empty = 4'h0;
    step(); chk("t3_pop_c1", {4'h0, pop}, 8'h02);
    step(); chk("t3_pop_c0a", {4'h0, pop}, 8'h01);
    step(); chk("t3_pop_c0b", {4'h0, pop}, 8'h01);
    step(); down_almost_full = 1'b1; #1;
    chk("t3_stall1_pop", {4'h0, pop}, 8'h00);
    chk("t3_stall1_vld", {7'h0, valid_out}, 8'h01);
    step();
    chk("t3_stall2_pop", {4'h0, pop}, 8'h00);
    chk("t3_stall2_vld", {7'h0, valid_out}, 8'h00);
    chk("t3_stall2_gnt", {6'h0, grant_id}, 8'h00);
    step();
    chk("t3_stall3_pop", {4'h0, pop}, 8'h00);
    step(); down_almost_full = 1'b0; #1;
    chk("t3_pop_c0c", {4'h0, pop}, 8'h01);
    step(); chk("t3_pop_c0d", {4'h0, pop}, 8'h01);
    step(); chk("t3_pop_c1b", {4'h0, pop}, 8'h02);

    // 4: only FIFO 2 holds data (5 entries, weight 2) -> five back-to-back pops, then idle.
    do_reset();
    weight_0 = 4'd1; weight_1 = 4'd1; weight_2 = 4'd2; weight_3 = 4'd1;
    fifo_empty = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t4_pop%0d", i), {4'h0, pop}, 8'h04);
      chk($sformatf("t4_gnt%0d", i), {6'h0, grant_id}, 8'h02);
    end
    step(); fifo_empty = 4'hF; #1;
    chk("t4_drain_pop", {4'h0, pop}, 8'h00);
    chk("t4_drain_vld", {7'h0, valid_out}, 8'h01);
    step();
    chk("t4_idle_pop", {4'h0, pop}, 8'h00);
    chk("t4_idle_vld", {7'h0, valid_out}, 8'h00);
    chk("t4_idle_gnt", {6'h0, grant_id}, 8'h02);

    // 5: FIFO 1 drains with credit left -> one bubble, then class 2.
    do_reset();
    weight_0 = 4'd4; weight_1 = 4'd4; weight_2 = 4'd4; weight_3 = 4'd4;
    fifo_empty = 4'h0;
    step(); chk("t5_pop_c1", {4'h0, pop}, 8'h02);
    step(); fifo_empty = 4'b0010; #1;
    chk("t5_bubble_pop", {4'h0, pop}, 8'h00);
    chk("t5_bubble_vld", {7'h0, valid_out}, 8'h01);
    step();
    chk("t5_pop_c2", {4'h0, pop}, 8'h04);
    chk("t5_gnt_c2", {6'h0, grant_id}, 8'h02);
    chk("t5_vld_gap", {7'h0, valid_out}, 8'h00);
    step();
    chk("t5_pop_c2b", {4'h0, pop}, 8'h04);
    chk("t5_vld_c2b", {7'h0, valid_out}, 8'h01);

    // 6: reset mid-SERVE clears pop and valid_out without a clock edge.
    #2;
    reset_L = 1'b0;
    #1;
    chk("t6_rst_pop", {4'h0, pop}, 8'h00);
    chk("t6_rst_vld", {7'h0, valid_out}, 8'h00);
    chk("t6_rst_gnt", {6'h0, grant_id}, 8'h00);
    step();
    reset_L    = 1'b1;
    fifo_empty = 4'h0;
    #1;
    chk("t6_post_idle_pop", {4'h0, pop}, 8'h00);
    step();
    chk("t6_first_pop", {4'h0, pop}, 8'h02);
    chk("t6_first_gnt", {6'h0, grant_id}, 8'h01);
    chk("t6_first_vld", {7'h0, valid_out}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
